// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared constants and types for the multicycle MIPS control unit
// Contents: opcode constants, alu_op codes (shared with the ALU control decoder),
// state encodings, alu_src_b / pc_source select codes, control bundle struct.
// Optional: ILLEGAL_OP_TRAP_EN adds the HALT state encoding.
package mips_ctrl_pkg;

    localparam int ALUOP_W = 3;
    localparam int STATE_W = 4;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD  = 3'b000;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB  = 3'b001;
    localparam logic [ALUOP_W-1:0] ALUOP_RTYP = 3'b010;
    localparam logic [ALUOP_W-1:0] ALUOP_ADDI = 3'b011;
    localparam logic [ALUOP_W-1:0] ALUOP_ANDI = 3'b100;
    localparam logic [ALUOP_W-1:0] ALUOP_ORI  = 3'b101;
    localparam logic [ALUOP_W-1:0] ALUOP_XORI = 3'b110;
    localparam logic [ALUOP_W-1:0] ALUOP_SLTI = 3'b111;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
`ifdef ILLEGAL_OP_TRAP_EN
        S_IWB    = 4'd11,
        S_HALT   = 4'd12
`else
        S_IWB    = 4'd11
`endif
    } state_t;

    typedef struct packed {
        logic               pc_write;
        logic               pc_write_cond;
        logic [1:0]         pc_source;
        logic               i_or_d;
        logic               mem_read;
        logic               mem_write;
        logic               ir_write;
        logic               mem_to_reg;
        logic               reg_dst;
        logic               reg_write;
        logic               alu_src_a;
        logic [1:0]         alu_src_b;
        logic               zero_ext;
        logic [ALUOP_W-1:0] alu_op;
        logic               halted;
    } ctrl_t;

    function automatic logic is_ialu(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) ||
               (op == OP_XORI) || (op == OP_SLTI);
    endfunction

    function automatic logic [ALUOP_W-1:0] ialu_op(input logic [5:0] op);
        case (op)
            OP_ANDI: return ALUOP_ANDI;
            OP_ORI:  return ALUOP_ORI;
            OP_XORI: return ALUOP_XORI;
            OP_SLTI: return ALUOP_SLTI;
            default: return ALUOP_ADDI;
        endcase
    endfunction

endpackage

// File: rtl/mcc_output_decode.sv
// rtl/mcc_output_decode.sv - combinational state+opcode to control-bundle decode
// Ports: state (in, current FSM state), opcode (in, IR[31:26]), ctrl (out, control bundle).
// Optional: ILLEGAL_OP_TRAP_EN enables the HALT decode (halted=1).
module mcc_output_decode
    import mips_ctrl_pkg::*;
(
    input  state_t      state,
    input  logic [5:0]  opcode,
    output ctrl_t       ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_DECODE: begin
                // Speculative branch target computed while the opcode is decoded.
                ctrl.alu_src_b = SRCB_BRANCH;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_RTYP;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            S_IEXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ialu_op(opcode);
                // Logical immediates are zero-extended; addi/slti sign-extend.
                ctrl.zero_ext  = (opcode == OP_ANDI) || (opcode == OP_ORI) ||
                                 (opcode == OP_XORI);
            end
            S_IWB: begin
                ctrl.reg_write = 1'b1;
            end
`ifdef ILLEGAL_OP_TRAP_EN
            S_HALT: begin
                ctrl.halted = 1'b1;
            end
`endif
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multicycle MIPS main control FSM
// Ports: clk, rst (async active-high), opcode (IR[31:26]); outputs pc_write,
// pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
// reg_dst, reg_write, alu_src_a, alu_src_b, zero_ext, alu_op, halted.
// Optional: ILLEGAL_OP_TRAP_EN sends undefined opcodes to a sticky HALT state.
module multicycle_control_fsm
    import mips_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic [1:0]         pc_source,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic               zero_ext,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               halted
);

    state_t state;
    ctrl_t  ctrl_raw;
    ctrl_t  ctrl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:  state <= S_DECODE;
                S_DECODE: begin
                    if (opcode == OP_LW || opcode == OP_SW) state <= S_MEMADR;
                    else if (opcode == OP_RTYPE)            state <= S_EXEC;
                    else if (opcode == OP_BEQ)              state <= S_BRANCH;
                    else if (opcode == OP_J)                state <= S_JUMP;
                    else if (is_ialu(opcode))               state <= S_IEXEC;
`ifdef ILLEGAL_OP_TRAP_EN
                    else                                    state <= S_HALT;
`else
                    else                                    state <= S_FETCH;
`endif
                end
                S_MEMADR: state <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  state <= S_MEMWB;
                S_MEMWB:  state <= S_FETCH;
                S_MEMWR:  state <= S_FETCH;
                S_EXEC:   state <= S_ALUWB;
                S_ALUWB:  state <= S_FETCH;
                S_BRANCH: state <= S_FETCH;
                S_JUMP:   state <= S_FETCH;
                S_IEXEC:  state <= S_IWB;
                S_IWB:    state <= S_FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
                S_HALT:   state <= S_HALT;
`endif
                default:  state <= S_FETCH;
            endcase
        end
    end

    mcc_output_decode u_decode (
        .state  (state),
        .opcode (opcode),
        .ctrl   (ctrl_raw)
    );

    // State sits at FETCH during reset, so outputs are masked to keep every
    // strobe low until rst is released.
    assign ctrl = rst ? '0 : ctrl_raw;

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign pc_source     = ctrl.pc_source;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign zero_ext      = ctrl.zero_ext;
    assign alu_op        = ctrl.alu_op;
    assign halted        = ctrl.halted;

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main control unit of the multicycle MIPS CPU. It is the producer side of the 3-bit ALU-operation interface that the ALU control decoder consumes.
- Sequences each instruction through FETCH/DECODE/execute/memory/writeback states.
- Drives datapath enables, mux selects and the ALU-operation code from the 6-bit opcode held in the IR.

Parameters:
- ALUOP_W, 3, width of alu_op. Fixed encoding below; other values are unsupported.
- STATE_W, 4, width of the state register.

Ports:
- clk  in  1  system clock; all state updates occur on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  6  IR[31:26]; stable from DECODE until the instruction retires.
- pc_write  out  1  unconditional PC write.
- pc_write_cond  out  1  PC write when the ALU zero flag is set.
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- i_or_d  out  1  memory address select: 0 PC, 1 ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  IR load.
- mem_to_reg  out  1  register writeback source: 0 ALUOut, 1 MDR.
- reg_dst  out  1  destination register: 0 rt, 1 rd.
- reg_write  out  1  register file write.
- alu_src_a  out  1  ALU A operand: 0 PC, 1 A register.
- alu_src_b  out  2  ALU B operand: 00 B, 01 const 4, 10 ext imm, 11 sext imm<<2.
- zero_ext  out  1  immediate extension: 1 zero-extend, 0 sign-extend.
- alu_op  out  ALUOP_W  operation code sent to the ALU control decoder.
- halted  out  1  illegal-opcode trap indicator.

Behaviour:
- alu_op encoding:
  - 000 add (lw/sw/PC+4/branch target)
  - 001 sub (beq)
  - 010 R-type, funct decoded downstream
  - 011 addi, 100 andi, 101 ori, 110 xori, 111 slti
- Opcodes:
  - R 000000, lw 100011, sw 101011, beq 000100, j 000010
  - addi 001000, andi 001100, ori 001101, xori 001110, slti 001010
- Reset: rst=1 forces the state to FETCH asynchronously. While rst is high, every output is 0. The first FETCH takes effect on the first rising edge after rst falls.
- The state register is the only storage. Outputs are decoded combinationally from the state, and in IEXEC also from opcode. Any output not listed for a state is 0.
- States, outputs and next-state transitions:
  - FETCH: mem_read, ir_write, pc_write, alu_src_b=01, alu_op=000 -> DECODE.
  - DECODE: alu_src_b=11, alu_op=000. Next state by opcode: lw/sw -> MEMADR; R -> EXEC; beq -> BRANCH; j -> JUMP; I-ALU -> IEXEC; other -> FETCH.
  - MEMADR: alu_src_a=1, alu_src_b=10 -> MEMRD (lw) or MEMWR (sw).
  - MEMRD: mem_read, i_or_d -> MEMWB.
  - MEMWB: reg_write, mem_to_reg -> FETCH.
  - MEMWR: mem_write, i_or_d -> FETCH.
  - EXEC: alu_src_a=1, alu_src_b=00, alu_op=010 -> ALUWB.
  - ALUWB: reg_write, reg_dst -> FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond, pc_source=01 -> FETCH.
  - JUMP: pc_write, pc_source=10 -> FETCH.
  - IEXEC: alu_src_a=1, alu_src_b=10, alu_op=011..111 per opcode; zero_ext=1 for andi/ori/xori -> IWB.
  - IWB: reg_write (reg_dst=0) -> FETCH.
  - HALT: only exists with the optional feature (see below).
- Instruction latency, FETCH to next FETCH: lw 5 cycles; sw, R-type and I-ALU 4 cycles; beq and j 3 cycles.
- mem_read and mem_write are never asserted together. pc_write and pc_write_cond are never asserted together.
- Unused state encodings go to FETCH on the next edge with all outputs 0.
- Reset mid-instruction: rst abandons the instruction immediately. No partial writeback strobe is issued after rst rises.

Optional Feature:
- Macro: ILLEGAL_OP_TRAP_EN.
- Defined: an undefined opcode in DECODE moves the FSM to HALT. HALT has all strobes at 0 and halted=1, and is left only by rst.
- Undefined: an undefined opcode returns to FETCH (a 2-cycle NOP), halted is tied to 0, and no HALT state is generated.

Decomposition:
- Shared package (mips_ctrl_pkg) holds:
  - opcode constants
  - alu_op constants (also used by the ALU control decoder)
  - state encodings
  - the alu_src_b and pc_source select constants
- One sub-module, mcc_output_decode: purely combinational state+opcode -> control outputs. The top level keeps the state register and next-state logic.

Test Plan:
- Reset: rst=1 mid-EXEC -> all outputs 0 the same cycle. After release, first cycle is FETCH (mem_read=1, ir_write=1, pc_write=1, alu_op=000).
- lw (100011): 5 cycles FETCH, DECODE, MEMADR, MEMRD, MEMWB. reg_write=1 and mem_to_reg=1 only in cycle 5; i_or_d=1 in cycle 4.
- R-type (000000) then sw (101011):
  - R-type: alu_op=010 in EXEC; reg_write=1 with reg_dst=1 in the 4th cycle.
  - sw: mem_write=1 only in its 4th cycle, with reg_write=0 throughout.
- beq (000100) and j (000010): each takes 3 cycles.
  - beq: alu_op=001, pc_write_cond=1, pc_source=01.
  - j: pc_write=1, pc_source=10.
- I-ALU sweep: in IEXEC, alu_op=011/100/101/110/111 and zero_ext=0/1/1/1/0 for addi/andi/ori/xori/slti.
- Opcode 111111:
  - Without ILLEGAL_OP_TRAP_EN: FETCH follows DECODE.
  - With it: halted=1 held for 20 cycles with no strobes, cleared by rst.
